// File: rtl/cam_power_seq.sv
// rtl/cam_power_seq.sv - per-channel camera power-down/reset sequencer
// Purpose: each channel steps OFF -> PWRUP -> BOOT -> READY. Every channel
//          enforces a minimum off time, a PWDN-to-RESETB interval and a
//          boot-to-ready interval, and can be restarted on its own.
// Optional feature macro: CAM_SEQ_RETRY_EN adds err_in-driven re-power with a
//          retry budget and a FAILED state. Without it, err_in is ignored and
//          fail is tied low.
// Ports:
//   xclk_cam     clock for all logic
//   reset_n      asynchronous active-low reset
//   cam_en       per-channel power request (level)
//   restart_req  per-channel single-cycle full power-cycle request
//   err_in       per-channel stream error (level, synchronous)
//   PWDN         per-channel sensor power-down, active high
//   RESETB       per-channel sensor reset, active low
//   cam_ready    per-channel booted and ready for SCCB configuration
//   all_ready    every enabled channel ready and at least one enabled
//   fail         per-channel retry budget exhausted
module cam_power_seq #(
    parameter int NUM_CAM   = 2,
    parameter int CNT_W     = 16,
    parameter int T_OFF     = 1024,
    parameter int T_PWDN    = 2500,
    parameter int T_INIT    = 20000,
    parameter int MAX_RETRY = 3
) (
    input  logic               xclk_cam,
    input  logic               reset_n,
    input  logic [NUM_CAM-1:0] cam_en,
    input  logic [NUM_CAM-1:0] restart_req,
    input  logic [NUM_CAM-1:0] err_in,
    output logic [NUM_CAM-1:0] PWDN,
    output logic [NUM_CAM-1:0] RESETB,
    output logic [NUM_CAM-1:0] cam_ready,
    output logic               all_ready,
    output logic [NUM_CAM-1:0] fail
);

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    if (NUM_CAM < 1 || NUM_CAM > 8) begin : g_bad_num_cam
        $error("cam_power_seq: NUM_CAM must be 1..8");
    end
    if (T_OFF < 1 || longint'(T_OFF) > CNT_MAX) begin : g_bad_t_off
        $error("cam_power_seq: T_OFF out of range for CNT_W");
    end
    if (T_PWDN < 1 || longint'(T_PWDN) > CNT_MAX) begin : g_bad_t_pwdn
        $error("cam_power_seq: T_PWDN out of range for CNT_W");
    end
    if (T_INIT < 1 || longint'(T_INIT) > CNT_MAX) begin : g_bad_t_init
        $error("cam_power_seq: T_INIT out of range for CNT_W");
    end
    if (MAX_RETRY < 0) begin : g_bad_max_retry
        $error("cam_power_seq: MAX_RETRY must not be negative");
    end

    localparam logic [CNT_W-1:0] T_OFF_C    = CNT_W'(T_OFF);
    localparam logic [CNT_W-1:0] T_PWDN_END = CNT_W'(T_PWDN - 1);
    localparam logic [CNT_W-1:0] T_INIT_END = CNT_W'(T_INIT - 1);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_PWRUP,
        ST_BOOT,
        ST_READY
`ifdef CAM_SEQ_RETRY_EN
        , ST_FAILED
`endif
    } state_t;

    state_t             state_q [NUM_CAM];
    state_t             state_d [NUM_CAM];
    logic [CNT_W-1:0]   cnt_q   [NUM_CAM];
    logic [CNT_W-1:0]   cnt_d   [NUM_CAM];
    logic [NUM_CAM-1:0] pwdn_q, pwdn_d;
    logic [NUM_CAM-1:0] resetb_q, resetb_d;
    logic [NUM_CAM-1:0] ready_q, ready_d;
    logic               all_ready_q, all_ready_d;
    logic [NUM_CAM-1:0] drop;

    // Either request drops a powered channel straight to OFF; both at once is one action.
    assign drop = ~cam_en | restart_req;

`ifdef CAM_SEQ_RETRY_EN
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);

    logic [RW-1:0]      retry_q [NUM_CAM];
    logic [RW-1:0]      retry_d [NUM_CAM];
    logic [NUM_CAM-1:0] fail_q, fail_d;
`else
    logic unused_err_in;
    assign unused_err_in = ^err_in;
`endif

    always_comb begin
        // cam_ready_q is one cycle old here, so all_ready lags cam_ready by a cycle.
        all_ready_d = (|cam_en) & (&(ready_q | ~cam_en));
        for (int i = 0; i < NUM_CAM; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
`ifdef CAM_SEQ_RETRY_EN
            retry_d[i] = retry_q[i];
`endif
            case (state_q[i])
                ST_OFF: begin
                    // restart_req is ignored here; the off-time counter keeps running.
                    if (cam_en[i] && cnt_q[i] == T_OFF_C) begin
                        state_d[i] = ST_PWRUP;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] != T_OFF_C) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                ST_PWRUP: begin
                    if (drop[i]) begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == T_PWDN_END) begin
                        state_d[i] = ST_BOOT;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                ST_BOOT: begin
                    if (drop[i]) begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == T_INIT_END) begin
                        state_d[i] = ST_READY;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                ST_READY: begin
                    if (drop[i]) begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = '0;
`ifdef CAM_SEQ_RETRY_EN
                    end else if (err_in[i]) begin
                        cnt_d[i] = '0;
                        if (retry_q[i] == MAX_RETRY_C) begin
                            state_d[i] = ST_FAILED;
                        end else begin
                            state_d[i] = ST_OFF;
                            retry_d[i] = retry_q[i] + 1'b1;
                        end
                    end else if (cnt_q[i] == T_INIT_END) begin
                        // Stable for a full T_INIT in READY: forgive earlier errors.
                        retry_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
`endif
                    end
                end
`ifdef CAM_SEQ_RETRY_EN
                ST_FAILED: begin
                    if (drop[i]) begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = '0;
                        retry_d[i] = '0;
                    end
                end
`endif
                default: begin
                    state_d[i] = ST_OFF;
                    cnt_d[i]   = '0;
                end
            endcase

            // Outputs are decoded from the next state so they change on the transition edge.
            pwdn_d[i]   = (state_d[i] == ST_OFF)
`ifdef CAM_SEQ_RETRY_EN
                          || (state_d[i] == ST_FAILED)
`endif
                          ;
            resetb_d[i] = (state_d[i] == ST_BOOT) || (state_d[i] == ST_READY);
            ready_d[i]  = (state_d[i] == ST_READY);
`ifdef CAM_SEQ_RETRY_EN
            fail_d[i]   = (state_d[i] == ST_FAILED);
`endif
        end
    end

    always_ff @(posedge xclk_cam or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CAM; i++) begin
                state_q[i] <= ST_OFF;
                cnt_q[i]   <= '0;
`ifdef CAM_SEQ_RETRY_EN
                retry_q[i] <= '0;
`endif
            end
            pwdn_q      <= '1;
            resetb_q    <= '0;
            ready_q     <= '0;
            all_ready_q <= 1'b0;
`ifdef CAM_SEQ_RETRY_EN
            fail_q      <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_CAM; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef CAM_SEQ_RETRY_EN
                retry_q[i] <= retry_d[i];
`endif
            end
            pwdn_q      <= pwdn_d;
            resetb_q    <= resetb_d;
            ready_q     <= ready_d;
            all_ready_q <= all_ready_d;
`ifdef CAM_SEQ_RETRY_EN
            fail_q      <= fail_d;
`endif
        end
    end

    assign PWDN      = pwdn_q;
    assign RESETB    = resetb_q;
    assign cam_ready = ready_q;
    assign all_ready = all_ready_q;
`ifdef CAM_SEQ_RETRY_EN
    assign fail      = fail_q;
`else
    assign fail      = '0;
`endif

endmodule

// File: doc/cam_power_seq.md
# cam_power_seq

Parametrised power-up and reset sequencer for NUM_CAM OV5640-class camera modules. It replaces the fixed single-delay RESETB release with an independent state machine per camera. Each machine enforces minimum power-down, PWDN-to-RESETB and boot-to-ready intervals, and supports per-channel restart. It sits beside the SCCB master in the camera front end: `cam_ready` tells the configuration controller when a sensor may be addressed over SCCB.

## Interface
Parameters:
- NUM_CAM, 2, number of camera channels (1..8)
- CNT_W, 16, width of each channel's interval counter
- T_OFF, 1024, minimum cycles PWDN stays high before any power-up
- T_PWDN, 2500, cycles from PWDN low to RESETB high
- T_INIT, 20000, cycles from RESETB high to cam_ready high
- MAX_RETRY, 3, automatic re-power attempts per channel (used only with CAM_SEQ_RETRY_EN)

Ports:
- xclk_cam  in  1  clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- cam_en  in  NUM_CAM  level; channel is requested powered while high
- restart_req  in  NUM_CAM  single-cycle pulse; forces a full power cycle of that channel
- err_in  in  NUM_CAM  level, already synchronous to xclk_cam; channel stream error
- PWDN  out  NUM_CAM  sensor power-down, active high
- RESETB  out  NUM_CAM  sensor reset, active low
- cam_ready  out  NUM_CAM  channel booted and may be configured
- all_ready  out  1  every enabled channel is ready, and at least one channel is enabled
- fail  out  NUM_CAM  retry budget exhausted

## Operation
- Each channel has its own FSM, an interval counter of CNT_W bits, and a retry counter. All outputs are registered.
- OFF: PWDN=1, RESETB=0, cam_ready=0. The counter increments and saturates at T_OFF.
  - Go to PWRUP when cam_en=1 and the counter has reached T_OFF. The counter clears on the transition.
- PWRUP: PWDN=0, RESETB=0.
  - Go to BOOT when the counter reaches T_PWDN-1. The counter clears.
- BOOT: PWDN=0, RESETB=1.
  - Go to READY when the counter reaches T_INIT-1.
- READY: PWDN=0, RESETB=1, cam_ready=1. The counter is idle.
- FAILED (retry build only): PWDN=1, RESETB=0, fail=1.
  - Leave to OFF on restart_req, or on cam_en=0. The retry counter clears and the OFF counter clears.
- From PWRUP, BOOT or READY, either cam_en=0 or restart_req=1 sends the channel to OFF with the counter cleared. A full T_OFF off period is therefore always enforced.
- restart_req in OFF is ignored and does not clear the counter.
- cam_en=0 and restart_req=1 in the same cycle: go to OFF (single action).
- all_ready = OR(cam_en) AND the AND over i of (cam_ready[i] OR NOT cam_en[i]). It is registered, so it lags cam_ready by one cycle.
- Elaboration-time check: T_OFF, T_PWDN and T_INIT must each be at least 1 and at most 2^CNT_W-1. Otherwise raise $error.

## Timing
- During reset and at reset release: all channels in OFF with counter=0; PWDN all ones; RESETB, cam_ready, all_ready and fail all zero; retry counters zero.
- First power-up: with cam_en held high from reset release, PWDN falls at edge T_OFF+1 after reset release.
- Interval guarantees:
  - PWDN is low for exactly T_PWDN cycles before RESETB rises.
  - cam_ready rises exactly T_INIT cycles after RESETB rises.
- Drop timing: cam_en falling or restart_req sampled at edge k makes PWDN=1, RESETB=0 and cam_ready=0 at edge k+1.
- Asynchronous reset asserted mid-sequence returns every output to its reset value immediately, with no glitch-free requirement on the SCCB lines.
- Channels are fully independent; no cross-channel ordering is imposed.

## Configuration
- Macro CAM_SEQ_RETRY_EN.
- Defined:
  - err_in=1 while in READY sends the channel to OFF and increments its retry counter.
  - When the retry counter equals MAX_RETRY, an err_in in READY sends the channel to FAILED instead.
  - A channel that reaches READY and holds it for T_INIT cycles without an error clears its retry counter.
- Not defined: err_in is unused, fail is tied to 0, the FAILED state and the retry counters are not built.

## Test plan
Bench parameters: NUM_CAM=2, T_OFF=4, T_PWDN=8, T_INIT=16, MAX_RETRY=2.
- Reset release with cam_en=2'b11 -> PWDN falls at edge 5, RESETB rises at edge 13, cam_ready=2'b11 at edge 29, all_ready at edge 30.
- cam_en=2'b01 only -> channel 1 stays PWDN=1; all_ready=1 once cam_ready[0]=1.
- restart_req[0] pulse during BOOT -> PWDN[0]=1 next edge, then 4 OFF cycles, then the full 8/16 sequence again; channel 1 unaffected.
- cam_en[1] deasserted in the same cycle as restart_req[1] in READY -> one return to OFF; the re-power is delayed until cam_en[1] returns.
- With CAM_SEQ_RETRY_EN: three err_in[0] pulses, each in READY -> two re-power cycles, then fail[0]=1 with PWDN[0]=1; restart_req[0] clears fail[0] and sequences normally.
- Async reset_n low during PWRUP -> outputs return to reset values immediately; the sequence restarts from OFF after release.
